// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: fetch (if_*) vs load/store (dm_*), one transaction at a time.
// Optional MEM_ARB_RR_EN: round-robin arbitration instead of dm priority with starvation guard.
module mem_port_arbiter #(
   parameter int AW     = 16,
   parameter int DW     = 16,
   parameter int STARVE = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          dm_req,
   input  logic          dm_we,
   input  logic [AW-1:0] dm_addr,
   input  logic [DW-1:0] dm_wdata,
   output logic          dm_ack,
   output logic [DW-1:0] dm_rdata,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic          mem_ack,
   input  logic [DW-1:0] mem_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic OWN_IF = 1'b0;
   localparam logic OWN_DM = 1'b1;

   state_t        r_state;
   state_t        w_next;
   logic          r_owner;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [AW-1:0] r_mem_addr;
   logic [DW-1:0] r_mem_wdata;
   logic          r_if_ack;
   logic          r_dm_ack;
   logic [DW-1:0] r_if_rdata;
   logic [DW-1:0] r_dm_rdata;

   logic          w_owner;
   logic          w_mem_req;
   logic          w_mem_we;
   logic [AW-1:0] w_mem_addr;
   logic [DW-1:0] w_mem_wdata;
   logic          w_if_ack;
   logic          w_dm_ack;
   logic [DW-1:0] w_if_rdata;
   logic [DW-1:0] w_dm_rdata;

   logic          w_any_req;
   logic          w_grant_dm;

   assign w_any_req = if_req | dm_req;

`ifdef MEM_ARB_RR_EN
   logic r_last_grant;

   // On a tie the requester that did not win last time goes next.
   assign w_grant_dm = dm_req & (~if_req | (r_last_grant == OWN_IF));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_grant <= OWN_IF;
      end else if ((r_state == S_IDLE) && w_any_req) begin
         r_last_grant <= w_grant_dm;
      end
   end
`else
   logic [3:0] r_starve;

   assign w_grant_dm = dm_req & (~if_req | (r_starve < 4'(STARVE)));

   // Counts dm wins over a waiting fetch; it only advances below STARVE, so it saturates there.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_starve <= 4'd0;
      end else if (r_state == S_IDLE) begin
         if (!if_req) begin
            r_starve <= 4'd0;
         end else if (w_grant_dm) begin
            r_starve <= r_starve + 4'd1;
         end else begin
            r_starve <= 4'd0;
         end
      end
   end
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_any_req) w_next = S_ISSUE;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (mem_ack) w_next = S_DONE;
         S_DONE:  w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Next values of the registered outputs; the acks fire in DONE because they are set on leaving WAIT.
   always_comb begin
      w_owner     = r_owner;
      w_mem_req   = 1'b0;
      w_mem_we    = r_mem_we;
      w_mem_addr  = r_mem_addr;
      w_mem_wdata = r_mem_wdata;
      w_if_ack    = 1'b0;
      w_dm_ack    = 1'b0;
      w_if_rdata  = r_if_rdata;
      w_dm_rdata  = r_dm_rdata;
      case (r_state)
         S_IDLE: begin
            if (w_any_req) begin
               w_mem_req = 1'b1;
               w_owner   = w_grant_dm;
               if (w_grant_dm) begin
                  w_mem_we    = dm_we;
                  w_mem_addr  = dm_addr;
                  w_mem_wdata = dm_wdata;
               end else begin
                  w_mem_we    = 1'b0;
                  w_mem_addr  = if_addr;
                  w_mem_wdata = '0;
               end
            end
         end
         S_WAIT: begin
            if (mem_ack) begin
               w_mem_we = 1'b0;
               if (r_owner == OWN_IF) begin
                  w_if_ack   = 1'b1;
                  w_if_rdata = mem_rdata;
               end else begin
                  w_dm_ack = 1'b1;
                  if (!r_mem_we) w_dm_rdata = mem_rdata;
               end
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_owner     <= OWN_IF;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_if_ack    <= 1'b0;
         r_dm_ack    <= 1'b0;
         r_if_rdata  <= '0;
         r_dm_rdata  <= '0;
      end else begin
         r_owner     <= w_owner;
         r_mem_req   <= w_mem_req;
         r_mem_we    <= w_mem_we;
         r_mem_addr  <= w_mem_addr;
         r_mem_wdata <= w_mem_wdata;
         r_if_ack    <= w_if_ack;
         r_dm_ack    <= w_dm_ack;
         r_if_rdata  <= w_if_rdata;
         r_dm_rdata  <= w_dm_rdata;
      end
   end

   assign if_ack    = r_if_ack;
   assign if_rdata  = r_if_rdata;
   assign dm_ack    = r_dm_ack;
   assign dm_rdata  = r_dm_rdata;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;

endmodule
